// File: rtl/mem_access_wb_pkg.sv
// Shared types and helpers for the MEM-stage data-memory access block.
// Contents: FSM state enum, memSize encodings, captured-access control
// struct, and lane helpers (alignment test, byte enables, store replication).
package mem_access_wb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Control captured at the start of a bus transfer
    typedef struct packed {
        logic       mem_to_reg;
        logic       reg_write;
        logic       we;
        logic       is_unsigned;
        logic [1:0] size;
    } acc_ctl_t;

    // Byte always aligned, half needs even address, word (and 11) needs 4-byte alignment
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
        logic ok;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = ~lo[0];
            SZ_W:    ok = (lo == 2'b00);
            default: ok = (lo == 2'b00);
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            SZ_B:    be = 4'b0001 << lo;
            SZ_H:    be = 4'b0011 << lo;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate store data across all lanes so the bus only needs the byte enables
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            SZ_B:    w = {4{d[7:0]}};
            SZ_H:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_access_wb_if.sv
// Data-memory req/ready bus between the MEM stage (master) and memory (slave).
// Signals: dmem_req/dmem_we/dmem_addr/dmem_be/dmem_wdata (master -> slave),
//          dmem_ready/dmem_rdata (slave -> master).
interface mem_access_wb_if #(
    parameter int unsigned WORD_BITWIDTH = 32
);

    logic                     dmem_req;
    logic                     dmem_we;
    logic [WORD_BITWIDTH-1:0] dmem_addr;
    logic [3:0]               dmem_be;
    logic [WORD_BITWIDTH-1:0] dmem_wdata;
    logic                     dmem_ready;
    logic [WORD_BITWIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_be,
        output dmem_wdata,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_be,
        input  dmem_wdata,
        output dmem_ready,
        output dmem_rdata
    );

endinterface

// File: rtl/mem_access_wb_load_align.sv
// Combinational load extractor: selects the addressed byte/half of the read
// word and sign- or zero-extends it to a full register value.
// Ports: rdata (read word), addr_lo (address bits [1:0]), size (memSize code),
//        is_unsigned (zero-extend), mem_data (aligned, extended result).
module mem_access_wb_load_align
    import mem_access_wb_pkg::*;
#(
    parameter int unsigned WORD_BITWIDTH = 32
) (
    input  logic [WORD_BITWIDTH-1:0] rdata,
    input  logic [1:0]               addr_lo,
    input  logic [1:0]               size,
    input  logic                     is_unsigned,
    output logic [WORD_BITWIDTH-1:0] mem_data
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_c = rdata[7:0];
            2'd1:    byte_c = rdata[15:8];
            2'd2:    byte_c = rdata[23:16];
            default: byte_c = rdata[31:24];
        endcase
        half_c = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_B:    mem_data = {{(WORD_BITWIDTH-8){~is_unsigned & byte_c[7]}}, byte_c};
            SZ_H:    mem_data = {{(WORD_BITWIDTH-16){~is_unsigned & half_c[15]}}, half_c};
            default: mem_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_wb.sv
// MEM stage: performs loads/stores over the dmem req/ready bus and registers
// the MEM/WB boundary. A two-state FSM absorbs multi-cycle accesses while
// stall holds the upstream pipeline.
// Ports: clk, rst (async active-low); EX/MEM inputs (in_valid, memToReg,
//        regWrite, memRead, memWrite, memSize, memUnsigned, ALUresult,
//        regReadData2, regToWrite); stall (combinational), misalign (pulse);
//        dmem (bus master); wb_* MEM/WB register outputs.
module mem_access_wb
    import mem_access_wb_pkg::*;
#(
    parameter int unsigned WORD_BITWIDTH    = 32,
    parameter int unsigned REG_NUM_BITWIDTH = 5
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        in_valid,
    input  logic                        memToReg,
    input  logic                        regWrite,
    input  logic                        memRead,
    input  logic                        memWrite,
    input  logic [1:0]                  memSize,
    input  logic                        memUnsigned,
    input  logic [WORD_BITWIDTH-1:0]    ALUresult,
    input  logic [WORD_BITWIDTH-1:0]    regReadData2,
    input  logic [REG_NUM_BITWIDTH-1:0] regToWrite,

    output logic                        stall,
    output logic                        misalign,

    mem_access_wb_if.master             dmem,

    output logic                        wb_valid,
    output logic                        wb_memToReg,
    output logic                        wb_regWrite,
    output logic [REG_NUM_BITWIDTH-1:0] wb_regToWrite,
    output logic [WORD_BITWIDTH-1:0]    wb_ALUresult,
    output logic [WORD_BITWIDTH-1:0]    wb_memData
);

    localparam int unsigned W = WORD_BITWIDTH;
    localparam int unsigned R = REG_NUM_BITWIDTH;

    state_t         state_q;
    state_t         state_d;
    acc_ctl_t       ctl_q;
    logic [W-1:0]   addr_q;
    logic [W-1:0]   wdata_q;
    logic [3:0]     be_q;
    logic [R-1:0]   rd_q;

    logic           memop_c;
    logic           aligned_c;
    logic           we_in_c;
    logic           stall_c;
    logic           start_c;
    logic           pass_c;
    logic           drop_c;
    logic           done_c;
    logic           req_c;
    logic [W-1:0]   load_data_c;

    // Decode of the EX/MEM slot; read wins when both read and write are set
    assign memop_c   = in_valid & (memRead | memWrite);
    assign we_in_c   = memWrite & ~memRead;
    assign aligned_c = is_aligned(memSize, ALUresult[1:0]);

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (memop_c && aligned_c) state_d = ACCESS;
            ACCESS:  if (dmem.dmem_ready)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: which MEM/WB update happens this cycle and whether to stall
    always_comb begin
        stall_c = 1'b0;
        start_c = 1'b0;
        pass_c  = 1'b0;
        drop_c  = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!memop_c) begin
                    pass_c = 1'b1;
                end else if (!aligned_c) begin
                    drop_c = 1'b1;
                end else begin
                    start_c = 1'b1;
                    stall_c = 1'b1;
                end
            end
            ACCESS: begin
                if (dmem.dmem_ready) begin
                    done_c = 1'b1;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Combinational stall is forced low while reset is asserted
    assign stall = rst & stall_c;

    // Capture of the access; fields stay stable for the whole transfer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctl_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rd_q    <= '0;
        end else if (start_c) begin
            ctl_q.mem_to_reg  <= memToReg;
            ctl_q.reg_write   <= regWrite;
            ctl_q.we          <= we_in_c;
            ctl_q.is_unsigned <= memUnsigned;
            ctl_q.size        <= memSize;
            addr_q            <= ALUresult;
            be_q              <= lane_be(memSize, ALUresult[1:0]);
            wdata_q           <= we_in_c ? lane_wdata(memSize, regReadData2) : '0;
            rd_q              <= regToWrite;
        end
    end

    // Bus is quiet outside ACCESS
    assign req_c           = (state_q == ACCESS);
    assign dmem.dmem_req   = req_c;
    assign dmem.dmem_we    = req_c & ctl_q.we;
    assign dmem.dmem_addr  = req_c ? {addr_q[W-1:2], 2'b00} : '0;
    assign dmem.dmem_be    = req_c ? be_q : 4'b0000;
    assign dmem.dmem_wdata = req_c ? wdata_q : '0;

    mem_access_wb_load_align #(
        .WORD_BITWIDTH (W)
    ) u_load_align (
        .rdata       (dmem.dmem_rdata),
        .addr_lo     (addr_q[1:0]),
        .size        (ctl_q.size),
        .is_unsigned (ctl_q.is_unsigned),
        .mem_data    (load_data_c)
    );

    // MEM/WB register and misalign pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign      <= 1'b0;
            wb_valid      <= 1'b0;
            wb_memToReg   <= 1'b0;
            wb_regWrite   <= 1'b0;
            wb_regToWrite <= '0;
            wb_ALUresult  <= '0;
            wb_memData    <= '0;
        end else begin
            misalign <= drop_c;
            if (pass_c) begin
                wb_valid      <= in_valid;
                wb_regWrite   <= in_valid & regWrite;
                wb_memToReg   <= memToReg;
                wb_regToWrite <= regToWrite;
                wb_ALUresult  <= ALUresult;
                wb_memData    <= '0;
            end else if (drop_c) begin
                // Misaligned access retires without touching the bus or rd
                wb_valid      <= 1'b1;
                wb_regWrite   <= 1'b0;
                wb_memToReg   <= memToReg;
                wb_regToWrite <= regToWrite;
                wb_ALUresult  <= ALUresult;
                wb_memData    <= '0;
            end else if (start_c) begin
                wb_valid <= 1'b0;
            end else if (done_c) begin
                wb_valid      <= 1'b1;
                wb_regWrite   <= ctl_q.reg_write;
                wb_memToReg   <= ctl_q.mem_to_reg;
                wb_regToWrite <= rd_q;
                wb_ALUresult  <= addr_q;
                wb_memData    <= ctl_q.we ? '0 : load_data_c;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_wb.sv
// Scoreboard bench for mem_access_wb: stimulus pushes expected MEM/WB and bus
// records; independent monitors pop and compare when the DUT presents them.
module tb_mem_access_wb;
    import mem_access_wb_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid, memToReg, regWrite, memRead, memWrite, memUnsigned;
    logic [1:0]  memSize;
    logic [31:0] ALUresult, regReadData2;
    logic [4:0]  regToWrite;
    logic        stall, misalign;
    logic        wb_valid, wb_memToReg, wb_regWrite;
    logic [4:0]  wb_regToWrite;
    logic [31:0] wb_ALUresult, wb_memData;

    mem_access_wb_if #(.WORD_BITWIDTH(32)) bus ();

    mem_access_wb #(
        .WORD_BITWIDTH    (32),
        .REG_NUM_BITWIDTH (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .memToReg      (memToReg),
        .regWrite      (regWrite),
        .memRead       (memRead),
        .memWrite      (memWrite),
        .memSize       (memSize),
        .memUnsigned   (memUnsigned),
        .ALUresult     (ALUresult),
        .regReadData2  (regReadData2),
        .regToWrite    (regToWrite),
        .stall         (stall),
        .misalign      (misalign),
        .dmem          (bus),
        .wb_valid      (wb_valid),
        .wb_memToReg   (wb_memToReg),
        .wb_regWrite   (wb_regWrite),
        .wb_regToWrite (wb_regToWrite),
        .wb_ALUresult  (wb_ALUresult),
        .wb_memData    (wb_memData)
    );

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] md;
        logic        full;
        logic        md_chk;
    } wb_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
    } resp_t;

    wb_exp_t  wb_q[$];
    bus_exp_t bus_q[$];
    resp_t    resp_q[$];

    int checks   = 0;
    int failures = 0;
    int mis_seen = 0;
    int mis_exp  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=0x%08h exp=0x%08h", name, act, exp);
        end
    endtask

    task automatic exp_wb(input logic rw, input logic m2r, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] md,
                          input logic full, input logic md_chk);
        wb_exp_t e;
        e.rw = rw; e.m2r = m2r; e.rd = rd; e.alu = alu; e.md = md;
        e.full = full; e.md_chk = md_chk;
        wb_q.push_back(e);
    endtask

    task automatic exp_bus(input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata);
        bus_exp_t b;
        b.we = we; b.addr = addr; b.be = be; b.wdata = wdata;
        bus_q.push_back(b);
    endtask

    task automatic add_resp(input int lat, input logic [31:0] rdata);
        resp_t r;
        r.lat = lat; r.rdata = rdata;
        resp_q.push_back(r);
    endtask

    // Drive one EX/MEM slot and hold it while stall is high
    task automatic send(input string name, input logic v, input logic rd_, input logic wr,
                        input logic [1:0] sz, input logic uns, input logic rw, input logic m2r,
                        input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] d,
                        input int exp_stall);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        in_valid = v; memRead = rd_; memWrite = wr; memSize = sz; memUnsigned = uns;
        regWrite = rw; memToReg = m2r; regToWrite = rd; ALUresult = addr; regReadData2 = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (stall) n++;
            else done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout act=stall_stuck exp=release", name);
        end
        chk({name, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    endtask

    // Memory responder: answers each request after the queued latency
    initial begin
        resp_t r;
        int    cnt;
        bit    busy;
        busy = 1'b0;
        cnt = 0;
        r.lat = 0;
        r.rdata = '0;
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                busy = 1'b0;
                bus.dmem_ready = 1'b0;
            end else if (bus.dmem_req) begin
                if (!busy) begin
                    if (resp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL bus_no_response act=req exp=none");
                        r.lat = 0;
                        r.rdata = '0;
                    end else begin
                        r = resp_q.pop_front();
                    end
                    busy = 1'b1;
                    cnt = r.lat;
                end
                if (cnt == 0) begin
                    bus.dmem_ready = 1'b1;
                    bus.dmem_rdata = r.rdata;
                    busy = 1'b0;
                end else begin
                    bus.dmem_ready = 1'b0;
                    bus.dmem_rdata = $urandom;
                    cnt--;
                end
            end else begin
                bus.dmem_ready = 1'b0;
                bus.dmem_rdata = $urandom;
            end
        end
    end

    // MEM/WB monitor
    always @(negedge clk) begin
        wb_exp_t e;
        if (rst && wb_valid) begin
            if (wb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected act=rd%0d alu=0x%08h exp=none", wb_regToWrite, wb_ALUresult);
            end else begin
                e = wb_q.pop_front();
                chk("wb_regWrite", 32'(wb_regWrite), 32'(e.rw));
                if (e.full) begin
                    chk("wb_memToReg", 32'(wb_memToReg), 32'(e.m2r));
                    chk("wb_regToWrite", 32'(wb_regToWrite), 32'(e.rd));
                    chk("wb_ALUresult", wb_ALUresult, e.alu);
                end
                if (e.md_chk) chk("wb_memData", wb_memData, e.md);
            end
        end
    end

    // Bus request monitor: compares every cycle the request is up
    bus_exp_t cur_bus;
    bit       have_cur = 1'b0;
    bit       prev_req = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_req = 1'b0;
        end else begin
            if (bus.dmem_req) begin
                if (!prev_req) begin
                    if (bus_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL bus_unexpected act=addr 0x%08h exp=none", bus.dmem_addr);
                        have_cur = 1'b0;
                    end else begin
                        cur_bus = bus_q.pop_front();
                        have_cur = 1'b1;
                    end
                end
                if (have_cur) begin
                    chk("dmem_we", 32'(bus.dmem_we), 32'(cur_bus.we));
                    chk("dmem_addr", bus.dmem_addr, cur_bus.addr);
                    chk("dmem_be", 32'(bus.dmem_be), 32'(cur_bus.be));
                    chk("dmem_wdata", bus.dmem_wdata, cur_bus.wdata);
                end
            end
            prev_req = bus.dmem_req;
        end
    end

    always @(negedge clk) begin
        if (rst && misalign) mis_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 0; memToReg = 0; regWrite = 0; memRead = 0; memWrite = 0;
        memSize = SZ_W; memUnsigned = 0; ALUresult = '0; regReadData2 = '0; regToWrite = '0;
        #1 rst = 1'b0;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_ALUresult", wb_ALUresult, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // ALU op passes straight through
        exp_wb(1, 0, 5'd5, 32'h1234, 32'h0, 1, 0);
        send("alu", 1, 0, 0, SZ_W, 0, 1, 0, 5'd5, 32'h1234, 32'h0, 0);

        exp_bus(0, 32'h100, 4'b1111, 32'h0);
        add_resp(3, 32'hDEADBEEF);
        exp_wb(1, 1, 5'd6, 32'h100, 32'hDEADBEEF, 1, 1);
        send("lw", 1, 1, 0, SZ_W, 0, 1, 1, 5'd6, 32'h100, 32'h0, 4);

        exp_bus(0, 32'h100, 4'b1000, 32'h0);
        add_resp(0, 32'h80FF_FF00);
        exp_wb(1, 1, 5'd7, 32'h103, 32'hFFFFFF80, 1, 1);
        send("lb", 1, 1, 0, SZ_B, 0, 1, 1, 5'd7, 32'h103, 32'h0, 1);

        exp_bus(0, 32'h100, 4'b1000, 32'h0);
        add_resp(1, 32'h80FF_FF00);
        exp_wb(1, 1, 5'd7, 32'h103, 32'h00000080, 1, 1);
        send("lbu", 1, 1, 0, SZ_B, 1, 1, 1, 5'd7, 32'h103, 32'h0, 2);

        exp_bus(1, 32'h100, 4'b1100, 32'h12341234);
        add_resp(2, 32'hFFFFFFFF);
        exp_wb(0, 0, 5'd3, 32'h102, 32'h0, 1, 1);
        send("sh", 1, 0, 1, SZ_H, 0, 0, 0, 5'd3, 32'h102, 32'hABCD1234, 3);

        mis_exp++;
        exp_wb(0, 1, 5'd8, 32'h101, 32'h0, 0, 0);
        send("lw_mis", 1, 1, 0, SZ_W, 0, 1, 1, 5'd8, 32'h101, 32'h0, 0);

        exp_wb(1, 0, 5'd10, 32'h77, 32'h0, 1, 0);
        send("alu2", 1, 0, 0, SZ_W, 0, 1, 0, 5'd10, 32'h77, 32'h0, 0);

        exp_bus(0, 32'h100, 4'b1100, 32'h0);
        add_resp(1, 32'h8001_7FFF);
        exp_wb(1, 1, 5'd12, 32'h102, 32'hFFFF8001, 1, 1);
        send("lh", 1, 1, 0, SZ_H, 0, 1, 1, 5'd12, 32'h102, 32'h0, 2);

        exp_bus(0, 32'h100, 4'b0011, 32'h0);
        add_resp(0, 32'h1234_9ABC);
        exp_wb(1, 1, 5'd13, 32'h100, 32'h00009ABC, 1, 1);
        send("lhu", 1, 1, 0, SZ_H, 1, 1, 1, 5'd13, 32'h100, 32'h0, 1);

        exp_bus(1, 32'h100, 4'b0010, 32'hA5A5A5A5);
        add_resp(0, 32'hFFFFFFFF);
        exp_wb(0, 0, 5'd0, 32'h101, 32'h0, 1, 1);
        send("sb", 1, 0, 1, SZ_B, 0, 0, 0, 5'd0, 32'h101, 32'h000000A5, 1);

        exp_bus(1, 32'h104, 4'b1111, 32'hCAFEF00D);
        add_resp(1, 32'h0);
        exp_wb(0, 0, 5'd0, 32'h104, 32'h0, 1, 1);
        send("sw", 1, 0, 1, SZ_W, 0, 0, 0, 5'd0, 32'h104, 32'hCAFEF00D, 2);

        // Read and write both set, size code 11: word load
        exp_bus(0, 32'h108, 4'b1111, 32'h0);
        add_resp(0, 32'h11223344);
        exp_wb(1, 1, 5'd14, 32'h108, 32'h11223344, 1, 1);
        send("rdwr", 1, 1, 1, 2'b11, 0, 1, 1, 5'd14, 32'h108, 32'h99999999, 1);

        mis_exp++;
        exp_wb(0, 0, 5'd15, 32'h103, 32'h0, 0, 0);
        send("sh_mis", 1, 0, 1, SZ_H, 0, 0, 0, 5'd15, 32'h103, 32'h5555, 0);

        // Bubble carrying a load must not touch the bus or retire
        send("bubble", 0, 1, 0, SZ_W, 0, 1, 1, 5'd16, 32'h101, 32'h0, 0);

        exp_wb(1, 0, 5'd11, 32'h0BAD, 32'h0, 1, 0);
        send("alu3", 1, 0, 0, SZ_W, 0, 1, 0, 5'd11, 32'h0BAD, 32'h0, 0);

        in_valid = 0; memRead = 0; memWrite = 0;
        for (int i = 0; i < 50 && wb_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
        chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        chk("misalign_cycles", 32'(mis_seen), 32'(mis_exp));

        // Reset in the middle of a long load: no completion may be reported
        exp_bus(0, 32'h200, 4'b1111, 32'h0);
        add_resp(20, 32'h55);
        in_valid = 1; memRead = 1; memWrite = 0; memSize = SZ_W; memUnsigned = 0;
        regWrite = 1; memToReg = 1; regToWrite = 5'd9; ALUresult = 32'h200; regReadData2 = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_dmem_req", 32'(bus.dmem_req), 32'd1);
        chk("pre_rst_stall", 32'(stall), 32'd1);
        rst = 1'b0;
        in_valid = 0; memRead = 0;
        #1;
        chk("abort_dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("abort_stall", 32'(stall), 32'd0);
        chk("abort_wb_valid", 32'(wb_valid), 32'd0);
        chk("abort_wb_ALUresult", wb_ALUresult, 32'd0);
        chk("abort_wb_regToWrite", 32'(wb_regToWrite), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("post_rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("post_rst_stall", 32'(stall), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
